// File: rtl/axi_mem_slave_if.sv
// AXI bundle between a master agent and axi_mem_slave: 9-bit IDs, 4-bit LEN.
// The slave modport is the responder view; master drives the request channels.
interface axi_mem_slave_if #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned D_WIDTH = 16
);
  localparam int unsigned BPB = D_WIDTH / 8;

  logic [8:0]         awid;
  logic [A_WIDTH-1:0] awaddr;
  logic [3:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;

  logic [8:0]         wid;
  logic [D_WIDTH-1:0] wdata;
  logic [BPB-1:0]     wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [8:0]         bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  logic [8:0]         arid;
  logic [A_WIDTH-1:0] araddr;
  logic [3:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;

  logic [8:0]         rid;
  logic [D_WIDTH-1:0] rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI slave backed by a word-addressed memory; independent write and read FSMs,
// one outstanding burst each, FIXED/INCR/WRAP addressing.
module axi_mem_slave #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned MEM_DEPTH = 256
) (
  input logic            clk,
  input logic            rstn,
  axi_mem_slave_if.slave bus
);
  localparam int unsigned BPB       = D_WIDTH / 8;
  localparam int unsigned FULL_SIZE = $clog2(BPB);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [D_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [A_WIDTH-1:0] align(input logic [A_WIDTH-1:0] a);
    return a & ~A_WIDTH'(BPB - 1);
  endfunction

  function automatic logic legal(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [3:0] len);
    return (size == 3'(FULL_SIZE)) && (burst != 2'b11) &&
           ((burst != 2'b10) || (len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic logic in_range(input logic [A_WIDTH-1:0] a);
    return (a >> FULL_SIZE) < A_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [A_WIDTH-1:0] a);
    return IDX_W'(a >> FULL_SIZE);
  endfunction

  function automatic logic [A_WIDTH-1:0] next_addr(input logic [A_WIDTH-1:0] a,
                                                   input logic [3:0] len,
                                                   input logic [1:0] burst);
    logic [A_WIDTH-1:0] inc, mask, res;
    inc  = a + A_WIDTH'(BPB);
    mask = ((A_WIDTH'(len) + A_WIDTH'(1)) << FULL_SIZE) - A_WIDTH'(1);
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~mask) | (inc & mask);
      default: res = inc;
    endcase
    return res;
  endfunction

  // ---------------- write path ----------------
  w_state_e           w_state_q, w_state_d;
  logic [8:0]         w_id_q, w_id_d;
  logic [A_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [3:0]         w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]         w_burst_q, w_burst_d;
  logic               w_err_q, w_err_d, w_ill_q, w_ill_d;
  logic               aw_hs, w_hs, b_hs, mem_we;

  assign bus.awready = rstn && (w_state_q == WIdle);
  assign bus.wready  = (w_state_q == WData);
  assign bus.bvalid  = (w_state_q == WResp);
  assign bus.bid     = w_id_q;
  assign bus.bresp   = {w_err_q, 1'b0};

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bus.bvalid && bus.bready;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_ill_d   = w_ill_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: if (aw_hs) begin
        w_id_d    = bus.awid;
        w_addr_d  = align(bus.awaddr);
        w_len_d   = bus.awlen;
        w_burst_d = bus.awburst;
        w_cnt_d   = 4'd0;
        w_ill_d   = !legal(bus.awsize, bus.awburst, bus.awlen);
        w_err_d   = w_ill_d;
        w_state_d = WData;
      end
      WData: if (w_hs) begin
        mem_we   = !w_ill_q && in_range(w_addr_q);
        w_err_d  = w_err_q || (bus.wid != w_id_q) || !in_range(w_addr_q) ||
                   (bus.wlast != (w_cnt_q == w_len_q));
        w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
        w_cnt_d  = w_cnt_q + 4'd1;
        // Only the beat count terminates a burst; WLAST is just checked.
        if (w_cnt_q == w_len_q) w_state_d = WResp;
      end
      WResp: if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      w_ill_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_ill_q   <= w_ill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BPB; i++) begin
        if (bus.wstrb[i]) mem[word_idx(w_addr_q)][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e           r_state_q, r_state_d;
  logic [8:0]         r_id_q, r_id_d;
  logic [A_WIDTH-1:0] r_addr_q, r_addr_d, rd_addr;
  logic [3:0]         r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]         r_burst_q, r_burst_d, r_resp_q, r_resp_d;
  logic [D_WIDTH-1:0] r_data_q, r_data_d, rd_word;
  logic               r_ill_q, r_ill_d, rd_ok, ar_hs, r_hs;

  assign bus.arready = rstn && (r_state_q == RIdle);
  assign bus.rvalid  = (r_state_q == RData);
  assign bus.rid     = r_id_q;
  assign bus.rdata   = r_data_q;
  assign bus.rresp   = r_resp_q;
  assign bus.rlast   = (r_state_q == RData) && (r_cnt_q == r_len_q);

  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = bus.rvalid && bus.rready;

  // Fetch address is the incoming AR in idle, else the precomputed next beat.
  assign rd_addr = (r_state_q == RIdle) ? align(bus.araddr) : r_addr_q;
  assign rd_ok   = ((r_state_q == RIdle) ? legal(bus.arsize, bus.arburst, bus.arlen) : !r_ill_q)
                   && in_range(rd_addr);
  assign rd_word = rd_ok ? mem[word_idx(rd_addr)] : '0;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_ill_d   = r_ill_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    unique case (r_state_q)
      RIdle: if (ar_hs) begin
        r_id_d    = bus.arid;
        r_len_d   = bus.arlen;
        r_burst_d = bus.arburst;
        r_ill_d   = !legal(bus.arsize, bus.arburst, bus.arlen);
        r_addr_d  = next_addr(rd_addr, bus.arlen, bus.arburst);
        r_cnt_d   = 4'd0;
        r_data_d  = rd_word;
        r_resp_d  = rd_ok ? 2'b00 : 2'b10;
        r_state_d = RData;
      end
      RData: if (r_hs) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = RIdle;
        end else begin
          r_data_d = rd_word;
          r_resp_d = rd_ok ? 2'b00 : 2'b10;
          r_cnt_d  = r_cnt_q + 4'd1;
          r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_ill_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_ill_q   <= r_ill_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave against a word-array reference model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] wb_data [16];
  logic [1:0]  wb_strb [16];

  always #5 clk = ~clk;

  axi_mem_slave_if #(.A_WIDTH(16), .D_WIDTH(16)) bus ();

  axi_mem_slave #(.A_WIDTH(16), .D_WIDTH(16), .MEM_DEPTH(256)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int size, input int len, input int burst);
    return size == 1 && burst != 3 &&
           (burst != 2 || len == 1 || len == 3 || len == 7 || len == 15);
  endfunction

  function automatic bit ref_in_range(input int a);
    return (a / 2) < 256;
  endfunction

  function automatic int ref_next(input int a, input int len, input int burst);
    int bnd;
    if (burst == 0) return a;
    if (burst == 2) begin
      bnd = (len + 1) * 2;
      return (a / bnd) * bnd + ((a + 2) % bnd);
    end
    return (a + 2) % 65536;
  endfunction

  task automatic idle_inputs();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic send_aw(input int id, input int addr, input int len, input int size,
                         input int burst);
    bit hs = 0;
    int t = 0;
    bus.awid = 9'(id); bus.awaddr = 16'(addr); bus.awlen = 4'(len);
    bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk); hs = bus.awready; @(posedge clk); t++;
    end
    #1 bus.awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_w(input int id, input logic [15:0] data, input logic [1:0] strb,
                        input bit last);
    bit hs = 0;
    int t = 0;
    bus.wid = 9'(id); bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    bus.wvalid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk); hs = bus.wready; @(posedge clk); t++;
    end
    #1 bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("w_handshake", 64'(hs), 64'd1);
  endtask

  // Full write burst from wb_data/wb_strb; the model tracks memory and BRESP.
  task automatic do_write(input int id, input int addr, input int len, input int size,
                          input int burst, input int last_at, input int bad_id_beat,
                          input bit gaps);
    bit exp_err;
    bit legal;
    int a;
    int t;
    legal = ref_legal(size, len, burst);
    exp_err = !legal;
    send_aw(id, addr, len, size, burst);
    a = addr - addr % 2;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_w((b == bad_id_beat) ? (id ^ 1) : id, wb_data[b], wb_strb[b], b == last_at);
      if (b == bad_id_beat || (b == last_at) != (b == len)) exp_err = 1;
      if (!ref_in_range(a)) exp_err = 1;
      else if (legal) begin
        for (int i = 0; i < 2; i++)
          if (wb_strb[b][i]) ref_mem[a / 2][8*i +: 8] = wb_data[b][8*i +: 8];
      end
      a = ref_next(a, len, burst);
    end
    @(negedge clk);
    check("bvalid_latency", 64'(bus.bvalid), 64'd1);
    t = 0;
    while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
    repeat ($urandom_range(0, 2)) begin
      check("bid_hold", 64'(bus.bid), 64'(id));
      @(negedge clk);
    end
    check("bid", 64'(bus.bid), 64'(id));
    check("bresp", 64'(bus.bresp), exp_err ? 64'd2 : 64'd0);
    bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", 64'(bus.bvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int id, input int addr, input int len, input int size,
                         input int burst, input int first_stall, input bit rand_stall);
    bit hs = 0;
    bit ok;
    int t = 0;
    int a;
    int n;
    logic [15:0] exp_d;
    bus.arid = 9'(id); bus.araddr = 16'(addr); bus.arlen = 4'(len);
    bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk); hs = bus.arready; @(posedge clk); t++;
    end
    #1 bus.arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
    a = addr - addr % 2;
    for (int b = 0; b <= len; b++) begin
      ok = ref_legal(size, len, burst) && ref_in_range(a);
      exp_d = ok ? ref_mem[a / 2] : 16'h0;
      n = (b == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      bus.rready = 1'b0;
      repeat (n) begin
        @(negedge clk);
        check("rvalid_stall", 64'(bus.rvalid), 64'd1);
        check("rdata_stall", 64'(bus.rdata), 64'(exp_d));
        check("rid_stall", 64'(bus.rid), 64'(id));
        @(posedge clk); #1;
      end
      bus.rready = 1'b1;
      @(negedge clk);
      check("rvalid", 64'(bus.rvalid), 64'd1);
      check("rid", 64'(bus.rid), 64'(id));
      check("rdata", 64'(bus.rdata), 64'(exp_d));
      check("rresp", 64'(bus.rresp), ok ? 64'd0 : 64'd2);
      check("rlast", 64'(bus.rlast), 64'(b == len));
      @(posedge clk); #1;
      a = ref_next(a, len, burst);
    end
    bus.rready = 1'b0;
    @(negedge clk);
    check("rvalid_drop", 64'(bus.rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int len);
    for (int b = 0; b <= len; b++) begin
      wb_data[b] = 16'($urandom);
      wb_strb[b] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int id, addr, len, size, burst, last_at, bad;
    rstn = 1'b0;
    idle_inputs();
    #12;
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Preload every word so the model knows the whole memory.
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 16; b++) begin
        wb_data[b] = 16'($urandom); wb_strb[b] = 2'b11;
      end
      do_write(k, k * 32, 15, 1, 1, 15, -1, 0);
    end

    // INCR write then stalled read-back.
    for (int b = 0; b < 4; b++) begin wb_data[b] = 16'hA0 + 16'(b); wb_strb[b] = 2'b11; end
    do_write(5, 16'h10, 3, 1, 1, 3, -1, 0);
    do_read(9, 16'h10, 3, 1, 1, 3, 0);

    // WRAP read returns words 10, 11, 8, 9.
    for (int b = 0; b < 4; b++) begin wb_data[b] = 16'(b); wb_strb[b] = 2'b11; end
    do_write(1, 16'h10, 3, 1, 1, 3, -1, 0);
    do_read(2, 16'h14, 3, 1, 2, 0, 0);

    // Error cases: early WLAST, narrow size, out-of-range second beat.
    fill_random(3);
    do_write(3, 16'h40, 3, 1, 1, 1, -1, 0);
    do_read(4, 16'h20, 0, 0, 1, 0, 0);
    do_read(6, 16'h1FE, 1, 1, 1, 1, 0);

    // Concurrent bursts on disjoint regions.
    fill_random(3);
    fork
      do_write(7, 16'h60, 3, 1, 1, 3, -1, 1);
      do_read(8, 16'h120, 5, 1, 1, 0, 1);
    join

    // Reset in the middle of a write burst; completed beats persist.
    send_aw(11, 16'h40, 3, 1, 1);
    send_w(11, 16'h1111, 2'b11, 1'b0);
    ref_mem[16'h20] = 16'h1111;
    send_w(11, 16'h2222, 2'b11, 1'b0);
    ref_mem[16'h21] = 16'h2222;
    bus.wvalid = 1'b1; bus.wdata = 16'h3333; bus.wstrb = 2'b11;
    #2 rstn = 1'b0;
    #1;
    check("midrst_awready", 64'(bus.awready), 64'd0);
    check("midrst_wready", 64'(bus.wready), 64'd0);
    check("midrst_bvalid", 64'(bus.bvalid), 64'd0);
    check("midrst_bid", 64'(bus.bid), 64'd0);
    idle_inputs();
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    check("postrst_bvalid", 64'(bus.bvalid), 64'd0);
    check("postrst_awready", 64'(bus.awready), 64'd1);
    @(posedge clk); #1;
    wb_data[0] = 16'h4444; wb_strb[0] = 2'b01;
    do_write(12, 16'h44, 0, 1, 1, 0, -1, 0);
    do_read(13, 16'h40, 3, 1, 1, 0, 0);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      id = $urandom_range(0, 511);
      len = $urandom_range(0, 15);
      size = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : 1;
      burst = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      fill_random(len);
      case ($urandom_range(0, 2))
        0: do_write(id, $urandom_range(0, 16'h21F), len, size, burst, last_at, bad, 1);
        1: do_read(id, $urandom_range(0, 16'h21F), len, size, burst,
                   $urandom_range(0, 2), 1);
        default: begin
          addr = $urandom_range(0, 16'hEF);
          len = $urandom_range(0, 7);
          fork
            do_write(id, addr, len, 1, 1, len, -1, 1);
            do_read(id ^ 3, $urandom_range(16'h100, 16'h1DF), len, 1, 1, 0, 1);
          join
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
